// File: rtl/fib_sched_pkg.sv
// Shared definitions for the Fibonacci kernel scheduler: controller state
// encoding, default sizing constants and a small width helper.
package fib_sched_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 1024;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_ABORT = 3'd4
   } fs_state_e;

   // Index width for a count of n items; never narrower than one bit so
   // degenerate configurations (one requester, TIMEOUT of 1) still elaborate.
   function automatic int fs_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fib_sched_rr.sv
// Combinational one-hot round-robin pick. The search starts just above the
// previous winner and wraps, so a requester that was just served has the
// lowest priority on the next pick.
module rr_arbiter
   import fib_sched_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W    = fs_idx_w(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last_grant,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_gnt_id,
   output logic               o_any
);

   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gnt_id;
   logic               w_found;

   // Two passes: first the indices above last_grant, then the wrap-around
   // part from 0 up to last_grant. First hit wins.
   always_comb begin
      w_gnt    = '0;
      w_gnt_id = '0;
      w_found  = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && (j > int'(i_last_grant)) && i_req[j]) begin
            w_found  = 1'b1;
            w_gnt[j] = 1'b1;
            w_gnt_id = ID_W'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!w_found && i_req[j]) begin
            w_found  = 1'b1;
            w_gnt[j] = 1'b1;
            w_gnt_id = ID_W'(j);
         end
      end
   end

   assign o_gnt    = w_gnt;
   assign o_gnt_id = w_gnt_id;
   assign o_any    = w_found;

endmodule

// File: rtl/fib_sched.sv
// Scheduler that shares one HLS-style Fibonacci kernel between NUM_REQ
// requesters. One request is in flight at a time; the kernel is started,
// watched for completion with a bounded busy timer, and reset if it hangs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | pick a requester round-robin and accept its operand
// ISSUE   | operand on k_n, waiting for kernel idle+ready to pulse k_start
// WAIT    | kernel running, busy counter advancing, watching k_done
// ABORT   | kernel overran the timeout; one-cycle kernel reset, error result
// RESP    | response presented, held until the consumer takes it
module fib_sched
   import fib_sched_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int TIMEOUT = DEF_TIMEOUT,
   localparam int ID_W    = fs_idx_w(NUM_REQ),
   localparam int CNT_W   = fs_idx_w(TIMEOUT)
)(
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   // requester side
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_n,
   output logic [NUM_REQ-1:0]        req_ready,
   // response side
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   // kernel side
   output logic                      k_start,
   output logic [DATA_W-1:0]         k_n,
   output logic                      k_rst,
   input  logic                      k_done,
   input  logic                      k_idle,
   input  logic                      k_ready,
   input  logic [DATA_W-1:0]         k_return
);

   localparam logic [ID_W-1:0]  LAST_GRANT_RST = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

   fs_state_e          r_state;
   logic [ID_W-1:0]    r_last_grant;
   logic [ID_W-1:0]    r_id;
   logic [DATA_W-1:0]  r_n;
   logic [CNT_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_rsp_data;
   logic               r_rsp_err;
   logic               r_rsp_valid;

   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gnt_id;
   logic               w_gnt_any;
   logic               w_idle_ok;
   logic               w_accept;
   logic               w_kick;
   logic               w_abort;
   logic [DATA_W-1:0]  w_opnd;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_gnt        (w_gnt),
      .o_gnt_id     (w_gnt_id),
      .o_any        (w_gnt_any)
   );

   // Grant and start are decoded from the current state so that an accept is
   // followed by k_start on the very next cycle. Both are masked while reset
   // is asserted so nothing is accepted or launched during a reset cycle.
   assign w_idle_ok = (r_state == S_IDLE) && !ap_rst;
   assign w_accept  = w_idle_ok && w_gnt_any;
   assign w_kick    = (r_state == S_ISSUE) && k_idle && k_ready && !ap_rst;
   assign w_abort   = (r_state == S_ABORT);

   // Operand of the granted requester (grant vector is one-hot).
   always_comb begin
      w_opnd = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_gnt[j]) begin
            w_opnd = w_opnd | req_n[j*DATA_W +: DATA_W];
         end
      end
   end

   // Controller: state, arbitration history, latched request, busy timer
   // and the response registers.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= LAST_GRANT_RST;
         r_id         <= '0;
         r_n          <= '0;
         r_cnt        <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_rsp_valid  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_id         <= w_gnt_id;
                  r_n          <= w_opnd;
                  r_last_grant <= w_gnt_id;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_kick) begin
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A done left high from the previous run is cleared by the
               // kernel on the start edge, so any done seen here is fresh.
               if (k_done) begin
                  r_rsp_data  <= k_return;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_ABORT;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_ABORT: begin
               r_rsp_data  <= '0;
               r_rsp_err   <= 1'b1;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = w_idle_ok ? w_gnt : '0;
   assign k_start   = w_kick;
   assign k_n       = r_n;
   assign k_rst     = ap_rst | w_abort;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched with a behavioural Fibonacci kernel and a
// response scoreboard filled at request acceptance.
module tb_fib_sched;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int TO = 16;

   logic             ap_clk = 1'b0;
   logic             ap_rst;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_n;
   logic [NR-1:0]    req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [DW-1:0]    rsp_data;
   logic             rsp_err;
   logic             k_start;
   logic [DW-1:0]    k_n;
   logic             k_rst;
   logic             k_done;
   logic             k_idle;
   logic             k_ready;
   logic [DW-1:0]    k_return;

   fib_sched #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_n     (req_n),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .k_start   (k_start),
      .k_n       (k_n),
      .k_rst     (k_rst),
      .k_done    (k_done),
      .k_idle    (k_idle),
      .k_ready   (k_ready),
      .k_return  (k_return)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic logic [31:0] fib(input logic [31:0] n);
      logic [31:0] a, b, t;
      a = 32'd0;
      b = 32'd1;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Kernel model: latency 2 + n%4 cycles, done held high until next start,
   // never finishes when hang is set.
   logic        hang;
   logic        k_busy;
   int          k_cnt;
   logic [31:0] k_res;

   always @(posedge ap_clk) begin
      if (k_rst) begin
         k_busy   <= 1'b0;
         k_done   <= 1'b0;
         k_return <= '0;
         k_cnt    <= 0;
      end else if (k_start) begin
         k_busy <= 1'b1;
         k_done <= 1'b0;
         k_cnt  <= 2 + int'(k_n % 32'd4);
         k_res  <= fib(k_n);
      end else if (k_busy && !hang) begin
         if (k_cnt == 0) begin
            k_busy   <= 1'b0;
            k_done   <= 1'b1;
            k_return <= k_res;
         end else begin
            k_cnt <= k_cnt - 1;
         end
      end
   end

   assign k_idle  = !k_busy;
   assign k_ready = !k_busy;

   logic [31:0] opnd [NR];
   always_comb begin
      req_n = '0;
      for (int i = 0; i < NR; i++) req_n[i*DW +: DW] = opnd[i];
   end

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   glog[$];

   int   n_cmp = 0;
   int   n_mis = 0;
   int   cyc = 0;
   int   rem [NR];
   logic acc_pend [NR];
   int   kst_cnt = 0, krst_cnt = 0, rsp_seen = 0, bad_oh = 0;
   int   t_acc = 0, t_start = 0, t_done = -1, t_rsp = 0, t_abort = 0;
   logic prev_rv = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: observe at negedge+1, cross the posedge, then retire accepts.
   task automatic tick();
      exp_t e;
      #1;
      cyc++;
      if ($countones(req_ready) > 1) bad_oh++;
      for (int i = 0; i < NR; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            e.id   = 2'(i);
            e.data = hang ? 32'd0 : fib(opnd[i]);
            e.err  = hang;
            sb.push_back(e);
            glog.push_back(i);
            acc_pend[i] = 1'b1;
            t_acc = cyc;
         end
      end
      if (k_start) begin
         kst_cnt++;
         t_start = cyc;
         t_done  = -1;
      end else if (k_done && t_done < 0) begin
         t_done = cyc;
      end
      if (k_rst && !ap_rst) begin
         krst_cnt++;
         t_abort = cyc;
      end
      if (rsp_valid && !prev_rv) t_rsp = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid) rsp_seen++;
      if (rsp_valid && rsp_ready) begin
         n_cmp++;
         assert (sb.size() > 0) else begin
            n_mis++;
            $error("FAIL rsp_unexpected: observed queue depth=%0d expected>0", sb.size());
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc_pend[i]) begin
            acc_pend[i] = 1'b0;
            rem[i]--;
            if (rem[i] <= 0) req_valid[i] = 1'b0;
         end
      end
      @(negedge ap_clk);
   endtask

   task automatic run_until_empty(input string tag, input int budget);
      int k;
      k = 0;
      while ((sb.size() != 0 || req_valid != '0) && k < budget) begin
         tick();
         k++;
      end
      check(tag, 64'(k < budget), 64'd1);
      tick();
   endtask

   task automatic do_reset();
      ap_rst = 1'b1;
      tick();
      tick();
      ap_rst = 1'b0;
      tick();
   endtask

   initial begin
      int   k;
      logic stable;
      int   rr_nz;
      logic [1:0]  s_id;
      logic [31:0] s_data;
      logic        s_err;

      ap_rst    = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '0;
      hang      = 1'b0;
      for (int i = 0; i < NR; i++) begin
         opnd[i]     = '0;
         rem[i]      = 0;
         acc_pend[i] = 1'b0;
      end
      @(negedge ap_clk);

      // reset state
      tick();
      tick();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_k_start", 64'(k_start), 64'd0);
      check("rst_k_rst", 64'(k_rst), 64'd1);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_k_n", 64'(k_n), 64'd0);
      ap_rst = 1'b0;
      tick();
      check("post_rst_k_rst", 64'(k_rst), 64'd0);

      // single request on requester 2, n=10
      kst_cnt = 0;
      opnd[2] = 32'd10; rem[2] = 1; req_valid[2] = 1'b1;
      run_until_empty("single_drain", 100);
      check("single_kstart_cnt", 64'(kst_cnt), 64'd1);
      check("lat_accept_to_start", 64'(t_start - t_acc), 64'd1);
      check("lat_done_to_rsp", 64'(t_rsp - t_done), 64'd1);

      // all four at once after reset: 0,1,2,3
      do_reset();
      glog.delete();
      for (int i = 0; i < NR; i++) begin
         opnd[i] = 32'(i + 1);
         rem[i]  = 1;
      end
      req_valid = 4'b1111;
      run_until_empty("all4_drain", 200);
      check("all4_grant_cnt", 64'(glog.size()), 64'd4);
      for (int i = 0; i < glog.size() && i < 4; i++) check("all4_grant_order", 64'(glog[i]), 64'(i));

      // requester 1 re-requests while 3 waits: 1,3,1,3
      glog.delete();
      opnd[1] = 32'd7; rem[1] = 2;
      opnd[3] = 32'd9; rem[3] = 2;
      req_valid = 4'b1010;
      run_until_empty("alt_drain", 200);
      check("alt_grant_cnt", 64'(glog.size()), 64'd4);
      for (int i = 0; i < glog.size() && i < 4; i++)
         check("alt_grant_order", 64'(glog[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

      // consumer stalls 20 cycles in RESP
      rsp_ready = 1'b0;
      opnd[0] = 32'd5; rem[0] = 1; req_valid[0] = 1'b1;
      k = 0;
      while (!rsp_valid && k < 100) begin
         tick();
         k++;
      end
      check("stall_rsp_reached", 64'(k < 100), 64'd1);
      opnd[1] = 32'd6; rem[1] = 1; req_valid[1] = 1'b1;
      kst_cnt = 0;
      s_id = rsp_id; s_data = rsp_data; s_err = rsp_err;
      stable = 1'b1; rr_nz = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!rsp_valid || rsp_id !== s_id || rsp_data !== s_data || rsp_err !== s_err) stable = 1'b0;
         if (req_ready != '0) rr_nz++;
      end
      check("stall_rsp_stable", 64'(stable), 64'd1);
      check("stall_req_ready_zero", 64'(rr_nz), 64'd0);
      check("stall_no_kstart", 64'(kst_cnt), 64'd0);
      check("stall_rsp_data", 64'(s_data), 64'd5);
      rsp_ready = 1'b1;
      run_until_empty("stall_drain", 200);

      // hung kernel: abort after TIMEOUT WAIT cycles
      hang = 1'b1;
      krst_cnt = 0;
      opnd[2] = 32'd7; rem[2] = 1; req_valid[2] = 1'b1;
      run_until_empty("abort_drain", 200);
      check("abort_krst_pulses", 64'(krst_cnt), 64'd1);
      check("abort_start_to_krst", 64'(t_abort - t_start), 64'(TO + 1));

      // reset mid-WAIT drops the request
      kst_cnt = 0;
      opnd[0] = 32'd3; rem[0] = 1; req_valid[0] = 1'b1;
      k = 0;
      while (kst_cnt == 0 && k < 20) begin
         tick();
         k++;
      end
      check("midwait_started", 64'(k < 20), 64'd1);
      repeat (5) tick();
      ap_rst = 1'b1;
      tick();
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd0);
      check("midrst_k_start", 64'(k_start), 64'd0);
      check("midrst_k_rst", 64'(k_rst), 64'd1);
      check("midrst_rsp_data", 64'(rsp_data), 64'd0);
      check("midrst_rsp_err", 64'(rsp_err), 64'd0);
      check("midrst_rsp_id", 64'(rsp_id), 64'd0);
      check("midrst_k_n", 64'(k_n), 64'd0);
      ap_rst = 1'b0;
      hang = 1'b0;
      sb.delete();
      rsp_seen = 0;
      repeat (30) tick();
      check("midrst_no_rsp", 64'(rsp_seen), 64'd0);
      check("midrst_no_restart", 64'(kst_cnt), 64'd1);

      check("req_ready_onehot", 64'(bad_oh), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fib_sched.md
FIB_SCHED -- requirements
Module: fib_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one kernel.
REQ-002 SHALL have parameter DATA_W, default 32, operand and result width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum kernel busy cycles before abort.
REQ-004 SHALL have port ap_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port ap_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester request strobe, held until accepted.
REQ-007 SHALL have port req_n  in  NUM_REQ*DATA_W  per-requester operand; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot accept; request i taken when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port rsp_valid  out  1  response available.
REQ-010 SHALL have port rsp_ready  in  1  response consumer accept.
REQ-011 SHALL have port rsp_id  out  clog2(NUM_REQ)  index of the requester the response belongs to.
REQ-012 SHALL have port rsp_data  out  DATA_W  kernel result (0 on error).
REQ-013 SHALL have port rsp_err  out  1  response produced by timeout abort.
REQ-014 SHALL have ports k_start out 1, k_n out DATA_W, k_rst out 1, k_done in 1, k_idle in 1, k_ready in 1, k_return in DATA_W; these drive and observe the kernel's ap_start, ap_n, ap_rst, ap_done, ap_idle, ap_ready, ap_return.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, ABORT.
REQ-016 IDLE: if any req_valid, SHALL grant round-robin, starting the search at (last_grant+1) mod NUM_REQ, and pulse req_ready[grant] for exactly one cycle.
REQ-017 On accept, SHALL latch grant id and operand, update last_grant, and go to ISSUE next cycle.
REQ-018 ISSUE: SHALL hold k_n = latched operand; assert k_start for exactly one cycle when k_idle and k_ready are high; wait otherwise; go to WAIT after the start cycle.
REQ-019 WAIT: SHALL count busy cycles from 0; when k_done is high, capture k_return into rsp_data, set rsp_err=0, and go to RESP.
REQ-020 WAIT: if the counter reaches TIMEOUT-1 without k_done, SHALL go to ABORT.
REQ-021 ABORT: SHALL assert k_rst for exactly one cycle, set rsp_data=0 and rsp_err=1, and go to RESP.
REQ-022 RESP: SHALL hold rsp_valid, rsp_id, rsp_data, and rsp_err stable until rsp_ready; on the handshake cycle, return to IDLE.
REQ-023 RESP with rsp_ready already high on entry SHALL complete in that single cycle; a new grant occurs in IDLE the following cycle, never in the same cycle.
REQ-024 SHALL ignore k_done in every state except WAIT; a stale high k_done from a previous run is cleared by the kernel on start and SHALL NOT end WAIT early.
REQ-025 k_rst SHALL equal ap_rst OR the abort pulse.
REQ-026 req_ready SHALL be zero outside IDLE; at most one bit SHALL be high at any time.
REQ-027 Latency, no contention: accept -> k_start is 1 cycle when the kernel is idle; k_done -> rsp_valid is 1 cycle.
REQ-028 The busy counter SHALL be clog2(TIMEOUT) bits wide, SHALL saturate, and SHALL be cleared on entry to WAIT.

Reset
REQ-029 On ap_rst: state=IDLE, last_grant=NUM_REQ-1 (first grant favours requester 0), counter=0.
REQ-030 On ap_rst, all outputs SHALL be 0 except k_rst=1; latched operand and id SHALL be 0.
REQ-031 Reset asserted in any state SHALL take effect next edge; in-flight request and pending response are dropped without a response.

Structure
REQ-032 The shared package SHALL hold the FSM state enum and the default constants NUM_REQ, DATA_W, and TIMEOUT.
REQ-033 SHALL contain one sub-module, rr_arbiter: a combinational one-hot round-robin pick from the request vector and last_grant.
REQ-034 All state registers SHALL be in fib_sched.

Verification
REQ-035 Single request: req_valid[2], n=10, kernel model = fib -> one k_start pulse; rsp_id=2, rsp_data=55, rsp_err=0.
REQ-036 All four valid at once after reset, n=1,2,3,4 -> grants in order 0,1,2,3; rsp_data 1,1,2,3.
REQ-037 Requester 1 re-asserts continuously while 3 waits -> grants alternate 1,3,1,3; no starvation.
REQ-038 rsp_ready low for 20 cycles in RESP -> rsp fields stable; req_ready stays 0; no second k_start.
REQ-039 Kernel model never asserts done, TIMEOUT=16 -> ABORT after 16 WAIT cycles; one k_rst pulse; rsp_err=1, rsp_data=0.
REQ-040 ap_rst pulsed mid-WAIT -> next cycle IDLE, outputs 0, k_rst=1; no response emitted for the dropped request.
